// File: rtl/fetch_debug_controller_pkg.sv
// Shared constants for the fetch debug controller: command bytes, state encoding, length width.
package fetch_debug_controller_pkg;

  // Width of the little-endian byte-count field that follows a load command
  localparam int unsigned NB_LENGTH = 16;

  // UART command bytes
  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RESET = 8'h52;  // 'R'

  // State encoding, also exported on o_state for debug
  localparam logic [2:0] STATE_IDLE        = 3'd0;
  localparam logic [2:0] STATE_LOAD_LEN_LO = 3'd1;
  localparam logic [2:0] STATE_LOAD_LEN_HI = 3'd2;
  localparam logic [2:0] STATE_LOAD_DATA   = 3'd3;
  localparam logic [2:0] STATE_RUN         = 3'd4;
  localparam logic [2:0] STATE_STEP        = 3'd5;
  localparam logic [2:0] STATE_FINISH      = 3'd6;

  typedef enum logic [2:0] {
    StIdle      = STATE_IDLE,
    StLoadLenLo = STATE_LOAD_LEN_LO,
    StLoadLenHi = STATE_LOAD_LEN_HI,
    StLoadData  = STATE_LOAD_DATA,
    StRun       = STATE_RUN,
    StStep      = STATE_STEP,
    StFinish    = STATE_FINISH
  } state_e;

endpackage

// File: rtl/fetch_debug_controller_load.sv
// Program-load bookkeeping: captures the byte count, tracks the byte index,
// flags bytes beyond memory capacity and generates the registered write strobe.
module program_load_counter
  import fetch_debug_controller_pkg::*;
#(
  parameter int unsigned NB_BYTE                = 8,
  parameter int unsigned NB_INSTRUCTION_ADDRESS = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_len_lo_valid,
  input  logic               i_len_hi_valid,
  input  logic               i_data_valid,
  input  logic [NB_BYTE-1:0] i_rx_data,
  output logic               o_len_zero,
  output logic               o_last_byte,
  output logic [NB_BYTE-1:0] o_load_byte,
  output logic               o_write_enable,
  output logic               o_overflow
);

  logic [NB_BYTE-1:0]   r_len_lo;
  logic [NB_LENGTH-1:0] r_length;
  logic [NB_LENGTH-1:0] r_index;
  logic [NB_BYTE-1:0]   r_load_byte;
  logic                 r_write_enable;
  logic                 r_overflow;
  logic                 w_in_range;

  // Index fits in memory when no bits above the address width are set
  assign w_in_range  = (r_index >> NB_INSTRUCTION_ADDRESS) == '0;
  assign o_len_zero  = ({i_rx_data, r_len_lo} == '0);
  assign o_last_byte = ((r_index + NB_LENGTH'(1)) == r_length);

  // Length capture, index tracking, overflow flag and one-cycle-latency write strobe
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_len_lo       <= '0;
      r_length       <= '0;
      r_index        <= '0;
      r_load_byte    <= '0;
      r_write_enable <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      if (i_start) begin
        r_overflow <= 1'b0;
        r_index    <= '0;
      end
      if (i_len_lo_valid) begin
        r_len_lo <= i_rx_data;
      end
      if (i_len_hi_valid) begin
        r_length <= NB_LENGTH'({i_rx_data, r_len_lo});
        r_index  <= '0;
      end
      if (i_data_valid) begin
        r_index <= r_index + NB_LENGTH'(1);
        if (w_in_range) begin
          r_load_byte    <= i_rx_data;
          r_write_enable <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign o_load_byte = r_load_byte;
  // A reset arriving while a strobe is pending suppresses it
  assign o_write_enable = r_write_enable & ~i_reset;
  assign o_overflow     = r_overflow;

endmodule

// File: rtl/fetch_debug_controller.sv
// Command sequencer in front of instruction fetch: load, run, step and PC reset
// driven by UART command bytes, with a run watchdog and a completion pulse.
module fetch_debug_controller
  import fetch_debug_controller_pkg::*;
#(
  parameter int unsigned NB_DATA                = 32,
  parameter int unsigned NB_BYTE                = 8,
  parameter int unsigned NB_INSTRUCTION_ADDRESS = 7,
  parameter int unsigned MAX_RUN_CYCLES         = 1024
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_is_end,
  output logic [NB_BYTE-1:0] o_load_program_byte,
  output logic               o_load_program_write_enable,
  output logic               o_pc_reset,
  output logic               o_pc_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout,
  output logic               o_load_overflow,
  output logic [NB_DATA-1:0] o_cycle_count,
  output logic [2:0]         o_state
);

  localparam int unsigned NB_RUN = $clog2(MAX_RUN_CYCLES + 1);

  state_e              r_state;
  state_e              w_next_state;
  logic                r_pc_reset;
  logic                r_timeout;
  logic [NB_DATA-1:0]  r_cycle_count;
  logic [NB_RUN-1:0]   r_run_count;

  logic w_cmd_load;
  logic w_cmd_run;
  logic w_cmd_reset;
  logic w_pc_enable;
  logic w_done;
  logic w_timeout_hit;
  logic w_len_zero;
  logic w_last_byte;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode, command acceptance and PC-enable generation
  always_comb begin
    w_next_state  = r_state;
    w_cmd_load    = 1'b0;
    w_cmd_run     = 1'b0;
    w_cmd_reset   = 1'b0;
    w_pc_enable   = 1'b0;
    w_done        = 1'b0;
    w_timeout_hit = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              w_cmd_load   = 1'b1;
              w_next_state = StLoadLenLo;
            end
            CMD_RUN: begin
              w_cmd_run    = 1'b1;
              w_next_state = StRun;
            end
            CMD_STEP:  w_next_state = i_is_end ? StFinish : StStep;
            CMD_RESET: begin
              w_cmd_reset  = 1'b1;
              w_next_state = StFinish;
            end
            default: w_next_state = StIdle;
          endcase
        end
      end
      StLoadLenLo: if (i_rx_valid) w_next_state = StLoadLenHi;
      StLoadLenHi: if (i_rx_valid) w_next_state = w_len_zero ? StFinish : StLoadData;
      StLoadData:  if (i_rx_valid && w_last_byte) w_next_state = StFinish;
      StRun: begin
        // Program end wins over the watchdog when both happen together
        if (i_is_end) begin
          w_next_state = StFinish;
        end else if (r_run_count == NB_RUN'(MAX_RUN_CYCLES)) begin
          w_timeout_hit = 1'b1;
          w_next_state  = StFinish;
        end else begin
          w_pc_enable = 1'b1;
        end
      end
      StStep: begin
        w_pc_enable  = 1'b1;
        w_next_state = StFinish;
      end
      StFinish: begin
        w_done       = 1'b1;
        w_next_state = StIdle;
      end
      default: w_next_state = StIdle;
    endcase
  end

  // PC-reset pulse, cycle counter, run watchdog counter and sticky timeout
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc_reset    <= 1'b0;
      r_cycle_count <= '0;
      r_run_count   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_pc_reset <= w_cmd_load | w_cmd_reset;
      if (w_cmd_load || w_cmd_reset) begin
        r_cycle_count <= '0;
      end else if (w_pc_enable) begin
        r_cycle_count <= r_cycle_count + NB_DATA'(1);
      end
      if (w_cmd_run) begin
        r_run_count <= '0;
      end else if (w_pc_enable && r_state == StRun) begin
        r_run_count <= r_run_count + NB_RUN'(1);
      end
      if (w_cmd_reset) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  program_load_counter #(
    .NB_BYTE               (NB_BYTE),
    .NB_INSTRUCTION_ADDRESS(NB_INSTRUCTION_ADDRESS)
  ) u_load (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_start       (w_cmd_load),
    .i_len_lo_valid(i_rx_valid && r_state == StLoadLenLo),
    .i_len_hi_valid(i_rx_valid && r_state == StLoadLenHi),
    .i_data_valid  (i_rx_valid && r_state == StLoadData),
    .i_rx_data     (i_rx_data),
    .o_len_zero    (w_len_zero),
    .o_last_byte   (w_last_byte),
    .o_load_byte   (o_load_program_byte),
    .o_write_enable(o_load_program_write_enable),
    .o_overflow    (o_load_overflow)
  );

  // Strobes are masked during reset so an abort never emits a stray pulse
  assign o_pc_enable   = w_pc_enable & ~i_reset;
  assign o_done        = w_done & ~i_reset;
  assign o_pc_reset    = r_pc_reset & ~i_reset;
  assign o_busy        = (r_state != StIdle);
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_debug_controller.sv
// Scoreboard bench: stimulus queues expected strobes with their cycle numbers,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_fetch_debug_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        is_end = 1'b0;
  logic [7:0]  load_byte;
  logic        we, pc_reset, pc_en, busy, done, timeout, overflow;
  logic [31:0] cycle_count;
  logic [2:0]  state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  rst_q[$];
  int  en_q[$];
  int  done_q[$];
  wr_t w;
  int  e;

  fetch_debug_controller dut (
    .i_clock                    (clk),
    .i_reset                    (rst),
    .i_rx_data                  (rx_data),
    .i_rx_valid                 (rx_valid),
    .i_is_end                   (is_end),
    .o_load_program_byte        (load_byte),
    .o_load_program_write_enable(we),
    .o_pc_reset                 (pc_reset),
    .o_pc_enable                (pc_en),
    .o_busy                     (busy),
    .o_done                     (done),
    .o_timeout                  (timeout),
    .o_load_overflow            (overflow),
    .o_cycle_count              (cycle_count),
    .o_state                    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Monitor: every strobe the DUT raises must match the head of its queue
  always @(negedge clk) begin
    if (we) begin
      chk("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        chk("write_cycle", cyc, w.cyc);
        chk("write_data", load_byte, w.data);
      end
    end
    if (pc_reset) begin
      chk("pc_reset_expected", rst_q.size() != 0, 1);
      if (rst_q.size() != 0) begin
        e = rst_q.pop_front();
        chk("pc_reset_cycle", cyc, e);
      end
    end
    if (pc_en) begin
      chk("pc_enable_expected", en_q.size() != 0, 1);
      if (en_q.size() != 0) begin
        e = en_q.pop_front();
        chk("pc_enable_cycle", cyc, e);
      end
    end
    if (done) begin
      chk("done_expected", done_q.size() != 0, 1);
      if (done_q.size() != 0) begin
        e = done_q.pop_front();
        chk("done_cycle", cyc, e);
      end
    end
    if (we || pc_en) chk("we_en_exclusive", we & pc_en, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    logic [7:0] d;
    logic [7:0] four[4];
    four[0] = 8'hAA; four[1] = 8'hBB; four[2] = 8'hCC; four[3] = 8'hDD;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_byte", load_byte, 0);
    tick(2);

    // Load of four bytes
    rst_q.push_back(cyc + 1);
    send(8'h4C);
    send(8'h04);
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back('{cyc + 1, four[i]});
      if (i == 3) done_q.push_back(cyc + 1);
      send(four[i]);
    end
    tick(3);
    chk("load4_overflow", overflow, 0);
    chk("load4_state", state, 0);

    // Load of 130 bytes: only 128 fit
    rst_q.push_back(cyc + 1);
    send(8'h4C);
    send(8'h82);
    send(8'h00);
    for (int i = 0; i < 130; i++) begin
      d = 8'(i) ^ 8'h5A;
      if (i < 128) wr_q.push_back('{cyc + 1, d});
      if (i == 129) done_q.push_back(cyc + 1);
      send(d);
    end
    tick(3);
    chk("load130_overflow", overflow, 1);

    // Run stopped by program end after 10 enable cycles
    c = cyc;
    for (int k = 1; k <= 10; k++) en_q.push_back(c + k);
    done_q.push_back(c + 12);
    send(8'h43);
    tick(10);
    is_end = 1'b1;
    tick(2);
    is_end = 1'b0;
    tick(1);
    chk("run10_count", cycle_count, 10);
    chk("run10_timeout", timeout, 0);

    // Run stopped by the watchdog
    c = cyc;
    for (int k = 1; k <= 1024; k++) en_q.push_back(c + k);
    done_q.push_back(c + 1026);
    send(8'h43);
    tick(1027);
    chk("wdog_timeout", timeout, 1);
    chk("wdog_count", cycle_count, 1034);

    // Reset during a run after 5 enable cycles
    c = cyc;
    for (int k = 1; k <= 5; k++) en_q.push_back(c + k);
    send(8'h43);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    chk("abort_enable", pc_en, 0);
    chk("abort_count", cycle_count, 0);
    chk("abort_timeout", timeout, 0);
    chk("abort_overflow", overflow, 0);
    tick(2);

    // Unknown byte is ignored
    send(8'h58);
    tick(2);
    chk("unknown_state", state, 0);
    chk("unknown_count", cycle_count, 0);

    // Three single steps
    for (int s = 0; s < 3; s++) begin
      c = cyc;
      en_q.push_back(c + 1);
      done_q.push_back(c + 2);
      send(8'h53);
      tick(2);
    end
    chk("step3_count", cycle_count, 3);

    // Step at program end: completion only
    is_end = 1'b1;
    done_q.push_back(cyc + 1);
    send(8'h53);
    tick(2);
    is_end = 1'b0;
    chk("step_end_count", cycle_count, 3);

    // 'L' during a run is ignored
    c = cyc;
    for (int k = 1; k <= 5; k++) en_q.push_back(c + k);
    done_q.push_back(c + 7);
    send(8'h43);
    tick(2);
    send(8'h4C);
    tick(2);
    is_end = 1'b1;
    tick(2);
    is_end = 1'b0;
    chk("run_ignore_count", cycle_count, 8);
    chk("run_ignore_state", state, 0);

    // PC reset command
    rst_q.push_back(cyc + 1);
    done_q.push_back(cyc + 1);
    send(8'h52);
    tick(2);
    chk("pcreset_count", cycle_count, 0);
    chk("pcreset_timeout", timeout, 0);

    // Every queued expectation must have been consumed
    tick(2);
    chk("writes_left", wr_q.size(), 0);
    chk("pc_resets_left", rst_q.size(), 0);
    chk("enables_left", en_q.size(), 0);
    chk("dones_left", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_debug_controller.md
Name: fetch_debug_controller

Overview:
- Command-driven sequencer in front of the instruction-fetch stage.
- Consumes a byte stream from the debug UART receiver and runs the fetch datapath in four modes: program load (byte-wise writes into instruction memory), continuous run, single step, and PC reset.
- Produces the load-byte, write-enable, PC-reset and PC-advance controls for fetch, plus a completion pulse for the downstream register-dump logic.

Parameters:
- NB_DATA, 32, width of cycle counter.
- NB_BYTE, 8, width of UART byte.
- NB_INSTRUCTION_ADDRESS, 7, instruction memory byte-address width; capacity = 2^NB_INSTRUCTION_ADDRESS bytes.
- NB_LENGTH, 16, width of load byte-count field.
- MAX_RUN_CYCLES, 1024, watchdog limit for continuous run.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_BYTE  received UART byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_is_end  in  1  fetch reports program end
- o_load_program_byte  out  NB_BYTE  byte to instruction memory
- o_load_program_write_enable  out  1  one-cycle write strobe
- o_pc_reset  out  1  one-cycle PC clear
- o_pc_enable  out  1  PC advance enable (drives fetch stall/advance input)
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at end of load/run/step/reset
- o_timeout  out  1  sticky, run ended by watchdog
- o_load_overflow  out  1  sticky, load exceeded memory capacity
- o_cycle_count  out  NB_DATA  PC-advance cycles since last PC reset
- o_state  out  3  current state encoding (debug)

Behaviour:
- Reset: state IDLE; all outputs 0, counters 0, sticky flags cleared. Reset mid-operation aborts immediately with no further write or enable strobes.
- Commands, accepted only in IDLE on i_rx_valid:
  - 'L' (0x4C): load.
  - 'C' (0x43): continuous run.
  - 'S' (0x53): single step.
  - 'R' (0x52): PC reset.
  - Any other byte is ignored; state stays IDLE.
  - i_rx_valid outside IDLE/LOAD_* is ignored.
- States: IDLE, LOAD_LEN_LO, LOAD_LEN_HI, LOAD_DATA, RUN, STEP, FINISH.
- Load:
  - On 'L': go to LOAD_LEN_LO, pulse o_pc_reset, clear o_cycle_count and o_load_overflow.
  - Next two valid bytes form length N, little-endian.
  - N=0 goes directly to FINISH.
  - In LOAD_DATA, each valid byte is registered to o_load_program_byte with o_load_program_write_enable high exactly the following cycle (1-cycle latency).
  - Byte index >= 2^NB_INSTRUCTION_ADDRESS: byte is consumed, no write strobe, o_load_overflow set.
  - After the N-th byte, go to FINISH.
- Run:
  - On 'C': o_pc_enable high from the next cycle, one cycle per cycle, each counted in o_cycle_count (wraps modulo 2^NB_DATA).
  - Stop when i_is_end is sampled high: o_pc_enable low that same cycle, go to FINISH.
  - If the run count reaches MAX_RUN_CYCLES: drop enable, set o_timeout, go to FINISH.
  - If i_is_end is already high on entry: zero enable cycles.
- Step:
  - On 'S': o_pc_enable high for exactly one cycle, counted; then FINISH.
  - If i_is_end is high at the command: no enable; FINISH.
- PC reset: on 'R', pulse o_pc_reset one cycle, clear o_cycle_count and o_timeout, go to FINISH.
- FINISH: o_done high one cycle, then IDLE.
- o_pc_enable and o_load_program_write_enable are never high in the same cycle.

Decomposition:
- Shared package holds:
  - command byte constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_RESET);
  - state encoding localparams;
  - NB_LENGTH.
- One natural sub-module: program_load_counter (length capture, byte index, overflow detect, write-strobe generation). The FSM and run watchdog stay in the top.

Test Plan:
- Reset in RUN after 5 enable cycles -> all outputs 0 next cycle, state IDLE, o_cycle_count=0.
- Bytes 0x4C,0x04,0x00,0xAA,0xBB,0xCC,0xDD -> o_pc_reset pulse after 0x4C; four write strobes carrying 0xAA..0xDD, each one cycle after its i_rx_valid; then o_done pulse; o_load_overflow=0.
- Load with N=130, NB_INSTRUCTION_ADDRESS=7 -> exactly 128 write strobes, o_load_overflow=1, o_done after byte 130.
- 'C' with i_is_end raised after 10 enable cycles -> o_pc_enable high 10 cycles, o_cycle_count=10, o_done pulse, o_timeout=0. Then 'C' with i_is_end held low -> 1024 enable cycles, o_timeout=1.
- Three 'S' commands -> three single-cycle o_pc_enable pulses, o_cycle_count=3, three o_done pulses. 'S' with i_is_end=1 -> no enable, o_done pulse.
- Byte 0x58 in IDLE -> no output change. 'L' sent during RUN -> ignored, run completes normally. 'R' -> o_pc_reset pulse, o_cycle_count=0.
